hilo_unit: RTL and testbench
============================

HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of HI/LO and each source.
REQ-002 SHALL have parameter NSRC, default 2, number of result sources (0 = multiplier, 1 = divider).
REQ-003 SHALL have parameter TIMEOUT, default 64, maximum WAIT cycles (used only with HILO_TIMEOUT_EN).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, launch of a mult/div operation.
REQ-007 SHALL have port src_sel, input, max(1,$clog2(NSRC)), source index for the launched operation.
REQ-008 SHALL have port src_done, input, NSRC, per-source result-ready pulse.
REQ-009 SHALL have port src_hi, input, NSRC*WIDTH, per-source HI results (source i at bits [i*WIDTH +: WIDTH]).
REQ-010 SHALL have port src_lo, input, NSRC*WIDTH, per-source LO results, same packing.
REQ-011 SHALL have ports wr_hi and wr_lo, input, 1 each, direct writes (mthi/mtlo).
REQ-012 SHALL have port wr_data, input, WIDTH, direct-write data.
REQ-013 SHALL have port rd_req, input, 1, mfhi/mflo read request.
REQ-014 SHALL have ports hi_out and lo_out, output, WIDTH each, registered HI/LO.
REQ-015 SHALL have port busy, output, 1, high in WAIT.
REQ-016 SHALL have port stall, output, 1, combinational rd_req & busy.
REQ-017 SHALL have port cap_pulse, output, 1, one-cycle pulse the cycle after a capture.
REQ-018 SHALL have port err, output, 1, sticky timeout flag.

Function
REQ-019 SHALL implement FSM states IDLE and WAIT; busy = (state == WAIT), registered.
REQ-020 IDLE: start with src_sel < NSRC SHALL latch src_sel into sel_q and move to WAIT next edge; start with src_sel >= NSRC SHALL be ignored.
REQ-021 WAIT: src_done[sel_q] SHALL load hi_out/lo_out from source sel_q at that edge (1-cycle latency), return to IDLE, and assert cap_pulse for the following cycle.
REQ-022 src_done from non-selected sources, and any src_done in IDLE, SHALL be ignored.
REQ-023 start in WAIT SHALL be ignored; sel_q SHALL hold.
REQ-024 wr_hi/wr_lo SHALL update the respective register from wr_data only in IDLE; in WAIT they SHALL be ignored.
REQ-025 IDLE with start and wr_hi in the same cycle: the write SHALL take effect and the operation SHALL launch.
REQ-026 hi_out/lo_out SHALL be unchanged except by capture or direct write.

Reset
REQ-027 reset SHALL force state IDLE, hi_out = lo_out = 0, sel_q = 0, busy = 0, cap_pulse = 0, err = 0; reset takes priority over all inputs, including mid-WAIT and same-cycle src_done.

Configuration
REQ-028 With HILO_TIMEOUT_EN defined: a cycle counter SHALL clear on entry to WAIT; if TIMEOUT cycles elapse in WAIT without src_done[sel_q], the FSM SHALL return to IDLE, leave hi_out/lo_out unchanged, and set err; err SHALL clear on the next accepted start or on reset; src_done arriving on the terminal cycle SHALL win (capture, no err).
REQ-029 Without HILO_TIMEOUT_EN: no counter SHALL exist, err SHALL be tied 0, and WAIT SHALL persist until src_done[sel_q].

Structure
REQ-030 State encodings and default WIDTH/NSRC/TIMEOUT constants SHALL reside in shared package hilo_pkg.
REQ-031 Source selection SHALL be a sub-module hilo_src_mux (NSRC-way, WIDTH-wide, index sel_q).

Verification
REQ-032 start, src_sel=1; 3 cycles later src_done=2'b10, src_hi=0xDEAD0001, src_lo=0x00000007 -> next cycle hi_out=0xDEAD0001, lo_out=7, busy=0, cap_pulse=1 for one cycle.
REQ-033 In WAIT on src 0, src_done=2'b10 -> no capture, busy stays 1; rd_req=1 -> stall=1.
REQ-034 IDLE, wr_lo=1, wr_data=0x12345678, start same cycle -> lo_out=0x12345678, busy=1; wr_hi during WAIT -> hi_out unchanged.
REQ-035 reset asserted in WAIT together with src_done -> hi_out=lo_out=0, busy=0, no cap_pulse.
REQ-036 HILO_TIMEOUT_EN, TIMEOUT=8, no src_done -> after 8 WAIT cycles busy=0, err=1, HI/LO unchanged; next start clears err; src_done on cycle 8 -> capture, err=0.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared constants and FSM state encoding for the HI/LO register unit.
package hilo_pkg;

  localparam int unsigned DEF_WIDTH   = 32;
  localparam int unsigned DEF_NSRC    = 2;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } hilo_state_t;

endpackage

// File: rtl/hilo_src_mux.sv
// NSRC-way selector of the done/HI/LO triple for the in-flight source.
module hilo_src_mux
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned NSRC  = DEF_NSRC,
  parameter int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1
) (
  input  logic [SEL_W-1:0]      sel,
  input  logic [NSRC-1:0]       done,
  input  logic [NSRC*WIDTH-1:0] hi_in,
  input  logic [NSRC*WIDTH-1:0] lo_in,
  output logic                  done_c,
  output logic [WIDTH-1:0]      hi_c,
  output logic [WIDTH-1:0]      lo_c
);

  always_comb begin
    done_c = 1'b0;
    hi_c   = '0;
    lo_c   = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (32'(sel) == i) begin
        done_c = done[i];
        hi_c   = hi_in[i*WIDTH +: WIDTH];
        lo_c   = lo_in[i*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register file fed by multi-cycle mult/div sources, with mthi/mtlo writes.
// Optional WAIT watchdog enabled by defining HILO_TIMEOUT_EN.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned NSRC    = DEF_NSRC,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic [((NSRC > 1) ? $clog2(NSRC) : 1)-1:0] src_sel,
  input  logic [NSRC-1:0]                        src_done,
  input  logic [NSRC*WIDTH-1:0]                  src_hi,
  input  logic [NSRC*WIDTH-1:0]                  src_lo,
  input  logic                                   wr_hi,
  input  logic                                   wr_lo,
  input  logic [WIDTH-1:0]                       wr_data,
  input  logic                                   rd_req,
  output logic [WIDTH-1:0]                       hi_out,
  output logic [WIDTH-1:0]                       lo_out,
  output logic                                   busy,
  output logic                                   stall,
  output logic                                   cap_pulse,
  output logic                                   err
);

  localparam int unsigned SEL_W = (NSRC > 1) ? $clog2(NSRC) : 1;

  hilo_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             cap_q, cap_d;
  logic             mux_done_c;
  logic [WIDTH-1:0] mux_hi_c, mux_lo_c;

`ifdef HILO_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT;
`endif

  hilo_src_mux #(
    .WIDTH (WIDTH),
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_src_mux (
    .sel    (sel_q),
    .done   (src_done),
    .hi_in  (src_hi),
    .lo_in  (src_lo),
    .done_c (mux_done_c),
    .hi_c   (mux_hi_c),
    .lo_c   (mux_lo_c)
  );

  // Next-state and next-register values
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cap_d   = 1'b0;
`ifdef HILO_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (wr_hi) hi_d = wr_data;
        if (wr_lo) lo_d = wr_data;
        if (start && (32'(src_sel) < NSRC)) begin
          sel_d   = src_sel;
          state_d = ST_WAIT;
`ifdef HILO_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_WAIT: begin
        // A result on the terminal cycle beats the watchdog.
        if (mux_done_c) begin
          hi_d    = mux_hi_c;
          lo_d    = mux_lo_c;
          cap_d   = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef HILO_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cap_q   <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cap_q   <= cap_d;
`ifdef HILO_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign hi_out    = hi_q;
  assign lo_out    = lo_q;
  assign busy      = (state_q == ST_WAIT);
  assign cap_pulse = cap_q;
  assign stall     = rd_req & busy;
`ifdef HILO_TIMEOUT_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hilo_unit.sv
// Directed self-checking bench for hilo_unit (HILO_TIMEOUT_EN section optional).
module tb_hilo_unit;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NSRC  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [0:0]        src_sel;
  logic [NSRC-1:0]   src_done;
  logic [NSRC*WIDTH-1:0] src_hi, src_lo;
  logic              wr_hi, wr_lo;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_req;
  logic [WIDTH-1:0]  hi_out, lo_out;
  logic              busy, stall, cap_pulse, err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  hilo_unit #(
    .WIDTH   (WIDTH),
    .NSRC    (NSRC),
    .TIMEOUT (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .src_sel   (src_sel),
    .src_done  (src_done),
    .src_hi    (src_hi),
    .src_lo    (src_lo),
    .wr_hi     (wr_hi),
    .wr_lo     (wr_lo),
    .wr_data   (wr_data),
    .rd_req    (rd_req),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .busy      (busy),
    .stall     (stall),
    .cap_pulse (cap_pulse),
    .err       (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; src_sel = '0; src_done = '0;
    src_hi = '0; src_lo = '0; wr_hi = 1'b0; wr_lo = 1'b0;
    wr_data = '0; rd_req = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_hi", hi_out, 32'h0);
    check("rst_lo", lo_out, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cap", 32'(cap_pulse), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Launch on source 1, result three cycles later
    start = 1'b1; src_sel = 1'b1;
    step();
    start = 1'b0;
    check("launch_busy", 32'(busy), 32'd1);
    step(); step();
    src_hi = {32'hDEAD0001, 32'hFFFFFFFF};
    src_lo = {32'h00000007, 32'hEEEEEEEE};
    src_done = 2'b10;
    step();
    src_done = 2'b00;
    check("cap1_hi", hi_out, 32'hDEAD0001);
    check("cap1_lo", lo_out, 32'h00000007);
    check("cap1_busy", 32'(busy), 32'd0);
    check("cap1_pulse", 32'(cap_pulse), 32'd1);
    step();
    check("cap1_pulse_off", 32'(cap_pulse), 32'd0);

    // Direct write of HI in IDLE
    wr_hi = 1'b1; wr_data = 32'hAAAA5555;
    step();
    wr_hi = 1'b0;
    check("mthi_idle", hi_out, 32'hAAAA5555);
    check("mthi_lo_kept", lo_out, 32'h00000007);

    // WAIT on source 0: done from source 1 ignored, start ignored, stall on read
    start = 1'b1; src_sel = 1'b0;
    step();
    start = 1'b0;
    src_done = 2'b10;
    step();
    src_done = 2'b00;
    check("wrong_src_busy", 32'(busy), 32'd1);
    check("wrong_src_hi", hi_out, 32'hAAAA5555);
    check("wrong_src_cap", 32'(cap_pulse), 32'd0);
    rd_req = 1'b1;
    #1;
    check("stall_wait", 32'(stall), 32'd1);
    start = 1'b1; src_sel = 1'b1;
    step();
    start = 1'b0;
    src_hi = {32'h99999999, 32'h11112222};
    src_lo = {32'h88888888, 32'h33334444};
    src_done = 2'b01;
    step();
    src_done = 2'b00;
    check("sel_held_hi", hi_out, 32'h11112222);
    check("sel_held_lo", lo_out, 32'h33334444);
    check("sel_held_cap", 32'(cap_pulse), 32'd1);
    #1;
    check("stall_idle", 32'(stall), 32'd0);
    rd_req = 1'b0;

    // Done pulses in IDLE are ignored
    src_done = 2'b11;
    step();
    src_done = 2'b00;
    check("idle_done_hi", hi_out, 32'h11112222);
    check("idle_done_busy", 32'(busy), 32'd0);
    check("idle_done_cap", 32'(cap_pulse), 32'd0);

    // mtlo and start in the same IDLE cycle; mthi in WAIT dropped
    wr_lo = 1'b1; wr_data = 32'h12345678; start = 1'b1; src_sel = 1'b0;
    step();
    wr_lo = 1'b0; start = 1'b0;
    check("wr_start_lo", lo_out, 32'h12345678);
    check("wr_start_busy", 32'(busy), 32'd1);
    wr_hi = 1'b1; wr_data = 32'hFFFF0000;
    step();
    wr_hi = 1'b0;
    check("mthi_wait_hi", hi_out, 32'h11112222);

    // Reset beats a same-cycle capture
    reset = 1'b1; src_done = 2'b01;
    step();
    reset = 1'b0; src_done = 2'b00;
    check("rst_wait_hi", hi_out, 32'h0);
    check("rst_wait_lo", lo_out, 32'h0);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_cap", 32'(cap_pulse), 32'd0);
    step();
    check("rst_wait_cap2", 32'(cap_pulse), 32'd0);

`ifdef HILO_TIMEOUT_EN
    // Watchdog: eight WAIT cycles without a result
    wr_hi = 1'b1; wr_data = 32'hCAFEF00D;
    step();
    wr_hi = 1'b0;
    start = 1'b1; src_sel = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("to_busy_c7", 32'(busy), 32'd1);
    step();
    check("to_busy", 32'(busy), 32'd0);
    check("to_err", 32'(err), 32'd1);
    check("to_hi", hi_out, 32'hCAFEF00D);
    start = 1'b1; src_sel = 1'b0;
    step();
    start = 1'b0;
    check("to_err_clr", 32'(err), 32'd0);
    for (int i = 0; i < 7; i++) step();
    src_hi = {32'h0, 32'h0BADBEEF};
    src_done = 2'b01;
    step();
    src_done = 2'b00;
    check("to_edge_hi", hi_out, 32'h0BADBEEF);
    check("to_edge_err", 32'(err), 32'd0);
    check("to_edge_cap", 32'(cap_pulse), 32'd1);
`else
    check("err_tied", 32'(err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
